// File: rtl/smips_controller.sv
// Multi-cycle Moore controller for the SMIPS stack machine datapath.
// Optional SMIPS_STEP_EN adds a single-step input that gates FETCH.
module smips_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic       z,
`ifdef SMIPS_STEP_EN
    input  logic       step,
`endif
    output logic       ld_pc,
    output logic       ld_B,
    output logic       ld_IR,
    output logic       ld_MDR,
    output logic       stack_src,
    output logic       mem_write_sig,
    output logic       push_sig,
    output logic       pop_sig,
    output logic       tos_sig,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       mem_adr_src,
    output logic       instr_done
);

    // state   | meaning
    // IDLE    | after reset, no activity
    // FETCH   | read IR from mem[PC], PC <= PC+1
    // DECODE  | present TOS, branch on opcode
    // MEM_RD  | MDR <= mem[addr]           (PUSH)
    // PUSH_WB | push MDR                   (PUSH)
    // MEM_WR  | mem[addr] <= TOS           (POP)
    // POP_WB  | pop                        (POP)
    // LD_B    | B <= TOS, pop              (ADD/SUB/AND)
    // ALU_WB  | replace TOS with ALU result
    // JMP     | PC <= addr
    // JZ      | pop, PC <= addr when z
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_RD, PUSH_WB, MEM_WR, POP_WB, LD_B, ALU_WB, JMP, JZ
    } state_t;

    typedef struct packed {
        logic       ld_pc;
        logic       ld_B;
        logic       ld_IR;
        logic       ld_MDR;
        logic       stack_src;
        logic       mem_write;
        logic       push;
        logic       pop;
        logic       tos;
        logic       pc_src;
        logic [1:0] alu_op;
        logic       mem_adr_src;
        logic       done;
    } ctl_t;

    state_t     state_q, state_d;
    ctl_t       ctl_q, ctl;
    logic [2:0] opcode;
    logic       fetch_go;
    logic       unused_addr;

    assign opcode      = instruction[7:5];
    assign unused_addr = ^instruction[4:0];

`ifdef SMIPS_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    function automatic ctl_t ctl_for(input state_t s, input logic [1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_adr_src = 1'b1; c.ld_IR = 1'b1; c.ld_pc = 1'b1; end
            DECODE:  c.tos = 1'b1;
            MEM_RD:  c.ld_MDR = 1'b1;
            PUSH_WB: begin c.push = 1'b1; c.done = 1'b1; end
            MEM_WR:  begin c.tos = 1'b1; c.mem_write = 1'b1; end
            POP_WB:  begin c.pop = 1'b1; c.done = 1'b1; end
            LD_B:    begin c.tos = 1'b1; c.ld_B = 1'b1; c.pop = 1'b1; end
            ALU_WB:  begin
                c.tos = 1'b1; c.alu_op = op; c.stack_src = 1'b1;
                c.pop = 1'b1; c.push = 1'b1; c.done = 1'b1;
            end
            JMP:     begin c.ld_pc = 1'b1; c.pc_src = 1'b1; c.done = 1'b1; end
            // ld_pc is qualified by z at the output, not here
            JZ:      begin c.tos = 1'b1; c.pop = 1'b1; c.pc_src = 1'b1; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (fetch_go) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    3'b100:  state_d = MEM_RD;
                    3'b101:  state_d = MEM_WR;
                    3'b011:  state_d = ALU_WB;
                    3'b110:  state_d = JMP;
                    3'b111:  state_d = JZ;
                    default: state_d = LD_B;
                endcase
            end
            MEM_RD:  state_d = PUSH_WB;
            MEM_WR:  state_d = POP_WB;
            LD_B:    state_d = ALU_WB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are registered alongside the state so they depend on the state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_for(state_d, opcode[1:0]);
        end
    end

    always_comb begin
        ctl = ctl_q;
        if (state_q == JZ) ctl.ld_pc = z;
        if (state_q == FETCH && !fetch_go) ctl = '0;
    end

    assign ld_pc         = ctl.ld_pc;
    assign ld_B          = ctl.ld_B;
    assign ld_IR         = ctl.ld_IR;
    assign ld_MDR        = ctl.ld_MDR;
    assign stack_src     = ctl.stack_src;
    assign mem_write_sig = ctl.mem_write;
    assign push_sig      = ctl.push;
    assign pop_sig       = ctl.pop;
    assign tos_sig       = ctl.tos;
    assign pc_src        = ctl.pc_src;
    assign alu_op        = ctl.alu_op;
    assign mem_adr_src   = ctl.mem_adr_src;
    assign instr_done    = ctl.done;

endmodule

// File: tb/tb_smips_controller.sv
// Scoreboard bench for smips_controller: driver queues hand-computed per-cycle
// output vectors, a monitor pops and compares them on the falling edge.
module tb_smips_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       z;
    logic       step;
    logic       ld_pc, ld_B, ld_IR, ld_MDR, stack_src, mem_write_sig;
    logic       push_sig, pop_sig, tos_sig, pc_src, mem_adr_src, instr_done;
    logic [1:0] alu_op;

    smips_controller dut (
        .clk(clk), .rst(rst), .instruction(instruction), .z(z),
`ifdef SMIPS_STEP_EN
        .step(step),
`endif
        .ld_pc(ld_pc), .ld_B(ld_B), .ld_IR(ld_IR), .ld_MDR(ld_MDR),
        .stack_src(stack_src), .mem_write_sig(mem_write_sig),
        .push_sig(push_sig), .pop_sig(pop_sig), .tos_sig(tos_sig),
        .pc_src(pc_src), .alu_op(alu_op), .mem_adr_src(mem_adr_src),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // {ld_pc, ld_B, ld_IR, ld_MDR, stack_src, mem_write, push, pop, tos, pc_src, alu_op[1:0], mem_adr_src, done}
    localparam logic [13:0] LDPC = 14'h2000, LDB = 14'h1000, LDIR = 14'h0800, LDMDR = 14'h0400;
    localparam logic [13:0] SSRC = 14'h0200, MW = 14'h0100, PSH = 14'h0080, POP = 14'h0040;
    localparam logic [13:0] TOS = 14'h0020, PCS = 14'h0010, MAS = 14'h0002, DONE = 14'h0001;

    localparam logic [13:0] E_FETCH = LDIR | LDPC | MAS;
    localparam logic [13:0] E_DEC   = TOS;
    localparam logic [13:0] E_MRD   = LDMDR;
    localparam logic [13:0] E_PWB   = PSH | DONE;
    localparam logic [13:0] E_MWR   = TOS | MW;
    localparam logic [13:0] E_PPWB  = POP | DONE;
    localparam logic [13:0] E_LDB   = TOS | LDB | POP;
    localparam logic [13:0] E_ALU   = TOS | SSRC | POP | PSH | DONE;
    localparam logic [13:0] E_ADD   = E_ALU;
    localparam logic [13:0] E_SUB   = E_ALU | 14'h0004;
    localparam logic [13:0] E_AND   = E_ALU | 14'h0008;
    localparam logic [13:0] E_NOT   = E_ALU | 14'h000C;
    localparam logic [13:0] E_JMP   = LDPC | PCS | DONE;
    localparam logic [13:0] E_JZ0   = TOS | POP | PCS | DONE;
    localparam logic [13:0] E_JZ1   = E_JZ0 | LDPC;

    logic [13:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          vec_idx = 0;

    wire [13:0] got = {ld_pc, ld_B, ld_IR, ld_MDR, stack_src, mem_write_sig,
                       push_sig, pop_sig, tos_sig, pc_src, alu_op, mem_adr_src, instr_done};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL vec%0d: outputs got %b want %b", vec_idx, got, e);
            end
            vec_idx++;
        end
    end

    // One clock: expectation for the state entered at this edge, inputs free after the sample.
    task automatic cyc(input logic [13:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic cyc_step_rise(input logic [13:0] e);
        @(posedge clk);
        #1;
        step = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instruction = 8'h00; z = 1'b0; step = 1'b1;

        cyc(14'h0); cyc(14'h0);
        rst = 1'b0;

`ifdef SMIPS_STEP_EN
        step = 1'b0;
        instruction = 8'h85;
        for (int i = 0; i < 5; i++) cyc(14'h0);
        cyc_step_rise(E_FETCH);
`else
        instruction = 8'h85;
        cyc(E_FETCH);
`endif
        // PUSH addr 5
        cyc(E_DEC); cyc(E_MRD); cyc(E_PWB);

        instruction = 8'h20;  // SUB
        cyc(E_FETCH); cyc(E_DEC); cyc(E_LDB); cyc(E_SUB);

        instruction = 8'hEA; z = 1'b1;  // JZ taken
        cyc(E_FETCH); cyc(E_DEC); cyc(E_JZ1);

        z = 1'b0;  // JZ not taken
        cyc(E_FETCH); cyc(E_DEC); cyc(E_JZ0);

        instruction = 8'hBF; z = 1'b1;  // POP addr 31, z must not leak outside JZ
        cyc(E_FETCH); cyc(E_DEC); cyc(E_MWR); cyc(E_PPWB);

        instruction = 8'h00;  // ADD
        cyc(E_FETCH); cyc(E_DEC); cyc(E_LDB); cyc(E_ADD);

        instruction = 8'h5F;  // AND
        cyc(E_FETCH); cyc(E_DEC); cyc(E_LDB); cyc(E_AND);

        instruction = 8'h7F;  // NOT skips LD_B
        cyc(E_FETCH); cyc(E_DEC); cyc(E_NOT);

        instruction = 8'hC3; z = 1'b0;  // JMP
        cyc(E_FETCH); cyc(E_DEC); cyc(E_JMP);

        instruction = 8'h3F;  // SUB, reset lands mid ALU_WB
        cyc(E_FETCH); cyc(E_DEC); cyc(E_LDB); cyc(E_SUB);
        rst = 1'b1;
        cyc(14'h0); cyc(14'h0);
        rst = 1'b0;
        cyc(14'h0 | E_FETCH);

        instruction = 8'h9F;  // PUSH aborted in MEM_RD: nothing may follow
        cyc(E_DEC); cyc(E_MRD);
        rst = 1'b1;
        cyc(14'h0);
        rst = 1'b0;
        cyc(E_FETCH); cyc(E_DEC); cyc(E_MRD); cyc(E_PWB);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time got %0t want <50000", $time);
        $fatal(1, "timeout");
    end

endmodule
